lsu_n: RTL and testbench
========================

Name: lsu_n

Overview:
- Load/store unit that executes the memory-access codes produced by the instruction decoder: `read_mem[2:0]` (loads) and `write_mem[1:0]` (stores).
- Sits between the EX stage and the data-memory bus.
- Issues one word-aligned transaction per request over a valid/ready memory interface, applies byte-lane strobes and replication for stores, and performs lane extraction plus sign/zero extension for loads.
- Reports misalignment, illegal codes and bus timeouts.

Parameters:
- `TIMEOUT`, 255, maximum cycles spent in WAIT before an error response; 0 disables the timeout.

Ports:
- `clk` input 1: system clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `req_valid` input 1: EX presents an access.
- `req_ready` output 1: LSU can accept; high only in IDLE.
- `read_mem` input 3: 000 none, 001 lw, 110 lh, 111 lb, 010 lhu, 011 lbu.
- `write_mem` input 2: 00 none, 01 sw, 10 sh, 11 sb.
- `addr` input 32: byte address, the ALU result.
- `wdata` input 32: store data, rs2.
- `resp_valid` output 1: one-cycle completion pulse.
- `rdata` output 32: extended load result; 0 for stores, errors and nops.
- `err` output 1: qualifies `resp_valid`; access failed.
- `mem_req_valid` output 1: bus request.
- `mem_req_ready` input 1: bus accepts request.
- `mem_we` output 1: 1 = write.
- `mem_addr` output 32: `{addr[31:2], 2'b00}`.
- `mem_wdata` output 32: lane-replicated store data.
- `mem_wstrb` output 4: byte enables; 0000 on reads.
- `mem_resp_valid` input 1: read data valid or write acknowledged.
- `mem_rdata` input 32: read word.

Behaviour:
- Reset (async, `rst_n` low): state IDLE, timeout counter 0, all registered request fields 0. All outputs 0 except `req_ready`, which is 1 in IDLE.
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - Accepts on `req_valid & req_ready` and latches `read_mem`, `write_mem`, `addr`, `wdata`.
  - Error check at accept: both codes nonzero, `read_mem` = 100 or 101, lw/sw with `addr[1:0]` != 0, or lh/lhu/sh with `addr[0]` != 0. An error goes to RESP with `err`=1 and no bus activity.
  - Both codes zero (nop) goes to RESP with `err`=0 and `rdata`=0.
  - Otherwise goes to REQ.
- REQ: `mem_req_valid`=1 with `mem_we`/`mem_addr`/`mem_wdata`/`mem_wstrb` held stable until `mem_req_ready`; then WAIT, counter cleared.
- WAIT:
  - On `mem_resp_valid`, capture the extracted result and go to RESP.
  - Counter increments each WAIT cycle. If `TIMEOUT` != 0 and the counter reaches `TIMEOUT` without a response, go to RESP with `err`=1 and `rdata`=0.
- RESP: `resp_valid`=1 for exactly one cycle with `rdata`/`err`; the next state is IDLE.
- `mem_resp_valid` seen in IDLE, REQ or RESP is ignored. This covers stale responses after reset or timeout.
- Latency: error/nop gives `resp_valid` 1 cycle after accept. Bus access with zero-wait memory gives `resp_valid` 3 cycles after accept (REQ, WAIT, RESP).
- Store lanes, with `o = addr[1:0]`:
  - sw: strb 1111, data `wdata`.
  - sh: strb 0011 if `o` = 00, 1100 if `o` = 10; data `{2{wdata[15:0]}}`.
  - sb: strb `4'b0001 << o`; data `{4{wdata[7:0]}}`.
- Load extraction:
  - byte = `mem_rdata[8*o+7 : 8*o]`.
  - half = `mem_rdata[16*o[1]+15 : 16*o[1]]`.
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word through.
- `req_ready`=0 outside IDLE, so the stage must hold its request. A new request can be accepted in the cycle after RESP.
- Reset mid-transaction aborts immediately. No response is produced for the aborted access.

Test Plan:
- lb at `addr`=0x8000_0003, `mem_rdata`=0x80FF_1234, zero-wait bus -> `mem_addr`=0x8000_0000, `mem_wstrb`=0000; `resp_valid` 3 cycles after accept, `rdata`=0xFFFF_FF80, `err`=0.
- lhu at 0x8000_0002, `mem_rdata`=0xBEEF_0000 -> `rdata`=0x0000_BEEF; lh at the same address -> `rdata`=0xFFFF_BEEF.
- sb at 0x1001, `wdata`=0x0000_00A5 -> `mem_we`=1, `mem_wstrb`=0010, `mem_wdata`=0xA5A5_A5A5; sh at 0x1002 -> `mem_wstrb`=1100; `rdata`=0 on completion.
- lw at 0x1002, and separately `read_mem`=001 with `write_mem`=01 -> no `mem_req_valid`; `resp_valid` with `err`=1 one cycle after accept.
- `mem_req_ready` held low 4 cycles, then response delayed 10 cycles with `TIMEOUT`=8 -> request fields stable throughout REQ; `err`=1 after 8 WAIT cycles; the late `mem_resp_valid` is ignored and the next lw completes normally.
- `rst_n` pulled low during WAIT -> outputs 0 immediately, `req_ready`=1 after release, no `resp_valid` for the aborted access.

Source files
------------

// File: rtl/lsu_n.sv
// lsu_n: load/store unit between the EX stage and the data-memory bus.
//
// Takes one access at a time from EX (read_mem/write_mem codes, byte
// address, store data). It issues a single word-aligned valid/ready bus
// transaction, applies byte strobes and lane replication for stores, and
// extracts and extends the addressed lane for loads.
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   req_valid / req_ready   EX request handshake (ready only in IDLE)
//   read_mem[2:0]           000 none, 001 lw, 110 lh, 111 lb, 010 lhu, 011 lbu
//   write_mem[1:0]          00 none, 01 sw, 10 sh, 11 sb
//   addr, wdata             byte address and store data
//   resp_valid, rdata, err  one-cycle completion pulse with result / error
//   mem_req_valid/_ready    bus request handshake
//   mem_we, mem_addr, mem_wdata, mem_wstrb   bus request fields
//   mem_resp_valid, mem_rdata                bus response
//
// Parameter TIMEOUT: WAIT cycles allowed before an error response (0 = never).
module lsu_n #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  read_mem,
  input  logic [1:0]  write_mem,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  // Counter value in the last permitted WAIT cycle; only used when TIMEOUT != 0.
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic [2:0]  rm_reg;
  logic [1:0]  wm_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] cnt_reg;
  logic [31:0] rdata_reg;
  logic        err_reg;

  logic        accept;
  logic        acc_err;
  logic        acc_nop;
  logic        timed_out;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;
  logic [31:0] store_data;
  logic [3:0]  store_strb;

  assign accept    = req_valid && (state_reg == S_IDLE);
  assign acc_nop   = (read_mem == 3'b000) && (write_mem == 2'b00);
  assign timed_out = (TIMEOUT != 0) && (cnt_reg == TIMEOUT_LAST);

  // Request legality, evaluated on the live inputs at accept time.
  always_comb begin
    acc_err = 1'b0;
    if ((read_mem != 3'b000) && (write_mem != 2'b00))
      acc_err = 1'b1;
    if ((read_mem == 3'b100) || (read_mem == 3'b101))
      acc_err = 1'b1;
    if (((read_mem == 3'b001) || (write_mem == 2'b01)) && (addr[1:0] != 2'b00))
      acc_err = 1'b1;
    if (((read_mem == 3'b110) || (read_mem == 3'b010) || (write_mem == 2'b10)) && addr[0])
      acc_err = 1'b1;
  end

  // Load lane extraction from the returned word.
  always_comb begin
    case (addr_reg[1:0])
      2'd0:    byte_sel = mem_rdata[7:0];
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = addr_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (rm_reg)
      3'b001:  load_val = mem_rdata;
      3'b110:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b010:  load_val = {16'h0000, half_sel};
      3'b111:  load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b011:  load_val = {24'h000000, byte_sel};
      default: load_val = 32'h0000_0000;   // stores complete with rdata 0
    endcase
  end

  // Store strobes and lane replication; the addressed lanes always carry the
  // right bytes, so the memory only has to honour the strobes.
  always_comb begin
    case (wm_reg)
      2'b01: begin
        store_strb = 4'b1111;
        store_data = wdata_reg;
      end
      2'b10: begin
        store_strb = addr_reg[1] ? 4'b1100 : 4'b0011;
        store_data = {2{wdata_reg[15:0]}};
      end
      2'b11: begin
        store_strb = 4'b0001 << addr_reg[1:0];
        store_data = {4{wdata_reg[7:0]}};
      end
      default: begin
        store_strb = 4'b0000;
        store_data = 32'h0000_0000;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_reg <= S_IDLE;
    else
      state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (accept) state_next = (acc_err || acc_nop) ? S_RESP : S_REQ;
      S_REQ:  if (mem_req_ready) state_next = S_WAIT;
      S_WAIT: if (mem_resp_valid || timed_out) state_next = S_RESP;
      S_RESP: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Request fields, timeout counter and response capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rm_reg    <= 3'b000;
      wm_reg    <= 2'b00;
      addr_reg  <= 32'h0000_0000;
      wdata_reg <= 32'h0000_0000;
      cnt_reg   <= 32'h0000_0000;
      rdata_reg <= 32'h0000_0000;
      err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            rm_reg    <= read_mem;
            wm_reg    <= write_mem;
            addr_reg  <= addr;
            wdata_reg <= wdata;
            rdata_reg <= 32'h0000_0000;
            err_reg   <= acc_err;
          end
        end
        S_REQ: begin
          if (mem_req_ready) cnt_reg <= 32'h0000_0000;
        end
        S_WAIT: begin
          if (mem_resp_valid) begin
            rdata_reg <= load_val;
            err_reg   <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + 32'd1;
            if (timed_out) begin
              rdata_reg <= 32'h0000_0000;
              err_reg   <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: bus fields are driven only in REQ and the response only in RESP,
  // so everything except req_ready reads 0 in IDLE and after reset.
  always_comb begin
    req_ready     = (state_reg == S_IDLE);
    mem_req_valid = (state_reg == S_REQ);
    mem_we        = 1'b0;
    mem_addr      = 32'h0000_0000;
    mem_wdata     = 32'h0000_0000;
    mem_wstrb     = 4'b0000;
    resp_valid    = (state_reg == S_RESP);
    rdata         = 32'h0000_0000;
    err           = 1'b0;
    if (state_reg == S_REQ) begin
      mem_we    = (wm_reg != 2'b00);
      mem_addr  = {addr_reg[31:2], 2'b00};
      mem_wdata = store_data;
      mem_wstrb = store_strb;
    end
    if (state_reg == S_RESP) begin
      rdata = rdata_reg;
      err   = err_reg;
    end
  end

endmodule

// File: tb/tb_lsu_n.sv
`timescale 1ns/1ps
module tb_lsu_n;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  read_mem;
  logic [1:0]  write_mem;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;

  lsu_n #(.TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .read_mem(read_mem), .write_mem(write_mem),
    .addr(addr), .wdata(wdata),
    .resp_valid(resp_valid), .rdata(rdata), .err(err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] rd;
    logic        er;
    int          acc;
    int          lat;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] word;
    int          rdy_dly;
    int          rsp_dly;
  } bus_t;

  exp_t exp_q[$];
  bus_t bus_q[$];
  bit   mem_busy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bounded wait until the DUT is idle and the memory model has drained.
  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready && !mem_busy) return;
    end
    total++;
    bad++;
    $display("FAIL idle_wait: got busy want idle within 200 cycles (cycle %0d)", cyc);
  endtask

  task automatic issue(input logic [2:0] rm, input logic [1:0] wm,
                       input logic [31:0] a, input logic [31:0] wd,
                       input bit has_bus, input logic [3:0] strb, input logic [31:0] bus_wd,
                       input logic [31:0] word, input int rdy_dly, input int rsp_dly,
                       input bit has_resp, input logic [31:0] exp_rd, input logic exp_er,
                       input int lat);
    bus_t b;
    exp_t e;
    wait_idle();
    req_valid = 1'b1;
    read_mem  = rm;
    write_mem = wm;
    addr      = a;
    wdata     = wd;
    if (has_bus) begin
      b.we = (wm != 2'b00); b.addr = {a[31:2], 2'b00}; b.wdata = bus_wd; b.strb = strb;
      b.word = word; b.rdy_dly = rdy_dly; b.rsp_dly = rsp_dly;
      bus_q.push_back(b);
    end
    if (has_resp) begin
      e.rd = exp_rd; e.er = exp_er; e.acc = cyc; e.lat = lat;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    read_mem  = 3'b000;
    write_mem = 2'b00;
    addr      = 32'h0;
    wdata     = 32'h0;
  endtask

  task automatic load(input logic [2:0] rm, input logic [31:0] a, input logic [31:0] word,
                      input logic [31:0] exp_rd);
    issue(rm, 2'b00, a, 32'h0, 1'b1, 4'b0000, 32'h0, word, 0, 0, 1'b1, exp_rd, 1'b0, 3);
  endtask

  task automatic store(input logic [1:0] wm, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] strb, input logic [31:0] bus_wd);
    issue(3'b000, wm, a, wd, 1'b1, strb, bus_wd, 32'h0, 0, 0, 1'b1, 32'h0, 1'b0, 3);
  endtask

  // No bus activity expected; response one cycle after accept.
  task automatic nobus(input logic [2:0] rm, input logic [1:0] wm, input logic [31:0] a,
                       input logic exp_er);
    issue(rm, wm, a, 32'h5555_AAAA, 1'b0, 4'b0000, 32'h0, 32'h0, 0, 0, 1'b1, 32'h0, exp_er, 1);
  endtask

  // Memory model: checks each bus request against the expected queue and
  // keeps its fields under observation while ready is held low.
  initial begin
    bus_t b;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_rdata      = 32'h0;
    forever begin
      @(negedge clk);
      if (mem_req_valid) begin
        if (bus_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL bus_unexpected: got request addr %h want none (cycle %0d)", mem_addr, cyc);
          mem_req_ready = 1'b1;
          @(posedge clk);
          #1 mem_req_ready = 1'b0;
        end else begin
          b = bus_q.pop_front();
          mem_busy = 1'b1;
          for (int i = 0; i <= b.rdy_dly; i++) begin
            if (i > 0) @(negedge clk);
            chk("mem_req_valid", {31'h0, mem_req_valid}, 32'h1);
            chk("mem_we", {31'h0, mem_we}, {31'h0, b.we});
            chk("mem_addr", mem_addr, b.addr);
            chk("mem_wstrb", {28'h0, mem_wstrb}, {28'h0, b.strb});
            if (b.we) chk("mem_wdata", mem_wdata, b.wdata);
          end
          mem_req_ready = 1'b1;
          @(posedge clk);
          #1 mem_req_ready = 1'b0;
          repeat (b.rsp_dly) begin
            @(posedge clk);
            #1;
          end
          mem_resp_valid = 1'b1;
          mem_rdata      = b.word;
          @(posedge clk);
          #1;
          mem_resp_valid = 1'b0;
          mem_rdata      = 32'h0;
          mem_busy       = 1'b0;
        end
      end
    end
  end

  // Response monitor / scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL resp_unexpected: got resp rdata=%h err=%b want none (cycle %0d)", rdata, err, cyc);
        end else begin
          e = exp_q.pop_front();
          $display("resp: rdata=%h err=%b latency=%0d", rdata, err, cyc - e.acc);
          chk("resp_rdata", rdata, e.rd);
          chk("resp_err", {31'h0, err}, {31'h0, e.er});
          chk("resp_latency", 32'(cyc - e.acc), 32'(e.lat));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish by 100us");
    $fatal(1, "watchdog");
  end

  task automatic check_quiet(input string tag);
    chk({tag, "_req_ready"}, {31'h0, req_ready}, 32'h1);
    chk({tag, "_resp_valid"}, {31'h0, resp_valid}, 32'h0);
    chk({tag, "_rdata"}, rdata, 32'h0);
    chk({tag, "_err"}, {31'h0, err}, 32'h0);
    chk({tag, "_mem_req_valid"}, {31'h0, mem_req_valid}, 32'h0);
    chk({tag, "_mem_we"}, {31'h0, mem_we}, 32'h0);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk({tag, "_mem_wstrb"}, {28'h0, mem_wstrb}, 32'h0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    read_mem  = 3'b000;
    write_mem = 2'b00;
    addr      = 32'h0;
    wdata     = 32'h0;
    #3;
    check_quiet("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Loads with lane extraction and extension.
    load(3'b111, 32'h8000_0003, 32'h80FF_1234, 32'hFFFF_FF80);   // lb
    load(3'b010, 32'h8000_0002, 32'hBEEF_0000, 32'h0000_BEEF);   // lhu
    load(3'b110, 32'h8000_0002, 32'hBEEF_0000, 32'hFFFF_BEEF);   // lh
    load(3'b011, 32'h0000_4001, 32'h1234_F6AB, 32'h0000_00F6);   // lbu
    load(3'b110, 32'h0000_4000, 32'h0000_7FFE, 32'h0000_7FFE);   // lh positive
    load(3'b001, 32'h0000_4000, 32'h89AB_CDEF, 32'h89AB_CDEF);   // lw

    // Stores: strobes and replication.
    store(2'b11, 32'h0000_1001, 32'h0000_00A5, 4'b0010, 32'hA5A5_A5A5); // sb
    store(2'b10, 32'h0000_1002, 32'h1234_ABCD, 4'b1100, 32'hABCD_ABCD); // sh high
    store(2'b10, 32'h0000_1000, 32'h0000_5A5A, 4'b0011, 32'h5A5A_5A5A); // sh low
    store(2'b11, 32'h0000_1003, 32'hFFFF_FF3C, 4'b1000, 32'h3C3C_3C3C); // sb lane 3
    store(2'b01, 32'h0000_2000, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D); // sw

    // Errors and nop: no bus activity, response one cycle after accept.
    nobus(3'b001, 2'b00, 32'h0000_1002, 1'b1);   // misaligned lw
    nobus(3'b001, 2'b01, 32'h0000_1000, 1'b1);   // both codes
    nobus(3'b100, 2'b00, 32'h0000_1000, 1'b1);   // illegal read code
    nobus(3'b000, 2'b10, 32'h0000_1001, 1'b1);   // misaligned sh
    nobus(3'b000, 2'b00, 32'h0000_1000, 1'b0);   // nop

    // Slow bus: ready low 4 cycles, response 10 cycles late -> timeout after 8 WAIT cycles.
    issue(3'b001, 2'b00, 32'h0000_3000, 32'h0, 1'b1, 4'b0000, 32'h0, 32'hDEAD_BEEF,
          4, 10, 1'b1, 32'h0, 1'b1, 14);
    load(3'b001, 32'h0000_3004, 32'h1122_3344, 32'h1122_3344);

    // Reset during WAIT aborts without a response.
    issue(3'b001, 2'b00, 32'h0000_5000, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h7777_7777,
          0, 6, 1'b0, 32'h0, 1'b0, 0);
    @(negedge clk);           // REQ, handshake at the next edge
    @(negedge clk);           // WAIT
    chk("wait_req_ready", {31'h0, req_ready}, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check_quiet("abort");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_req_ready", {31'h0, req_ready}, 32'h1);
    load(3'b111, 32'h0000_6002, 32'h0081_0000, 32'hFFFF_FF81);

    wait_idle();
    repeat (3) @(negedge clk);
    chk("resp_queue_empty", 32'(exp_q.size()), 32'h0);
    chk("bus_queue_empty", 32'(bus_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
